johnson_decoder: RTL and testbench
==================================

# johnson_decoder

Downstream consumer of the parameterized Johnson counter. It samples the counter's N-bit code every clock and decodes it to a binary phase index in 0..2N-1. It checks each code for legality and sequence continuity, reports wrap-around, and keeps a saturating error count. It sits between the counter and any logic that needs a binary phase, wrap strobe or health status.

## Interface
- N, 4, width of the Johnson code; legal range N ≥ 2; the sequence has 2N states.
- CW, 8, width of the error counter.
- Derived localparam IW = $clog2(2*N), the width of the index.
- clk  input  1  rising-edge clock, shared with the counter.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- q  input  N  Johnson code from the counter; already registered upstream, sampled directly.
- err_clr  input  1  synchronous clear of err_cnt.
- idx  output  IW  decoded phase index, registered.
- valid  output  1  idx is trustworthy (decoder in TRACK).
- illegal  output  1  one-cycle pulse: sampled code is not one of the 2N legal codes.
- seq_err  output  1  one-cycle pulse: legal code, but not the successor of (or equal to) the previous index.
- wrap  output  1  one-cycle pulse: index stepped 2N-1 → 0.
- err_cnt  output  CW  count of illegal + seq_err events, saturating at 2^CW-1.

## Operation
- Legal codes:
  - Index k in 0..N: code = 2^k − 1 (ones filled from bit 0).
  - Index k in N+1..2N−1: code = (2^N − 1) << (k−N), truncated to N bits.
  - N=4 sequence: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000.
- Decode of index k (p = popcount(q)):
  - q[N−1]=0: k = p; legal iff q == 2^p − 1.
  - q[N−1]=1: k = 2N − p; legal iff q == ones in the top p bits.
- FSM states: SYNC (no trusted previous index), TRACK.
  - SYNC, legal code: load idx=k, go to TRACK, valid=1. No seq_err is raised on first lock.
  - SYNC, illegal code: pulse illegal, stay in SYNC, idx holds its value.
  - TRACK, k == (idx+1) mod 2N: load idx=k, no error. Pulse wrap if idx was 2N−1 and k=0.
  - TRACK, k == idx (counter held in reset or stalled): no change, no error.
  - TRACK, any other legal k: pulse seq_err, load idx=k (resync), stay in TRACK.
  - TRACK, illegal code: pulse illegal, go to SYNC, valid=0, idx holds its value.
- err_cnt:
  - Increments by 1 on any cycle where illegal or seq_err pulses.
  - Saturates at 2^CW−1.
  - err_clr has priority: a clear in the same cycle as an error event yields 0.
- illegal and seq_err are mutually exclusive by construction.

## Timing
- All outputs are registered. A code present at rising edge t is reflected in idx/valid/pulses after edge t, i.e. one cycle of latency.
- Pulses (illegal, seq_err, wrap) are high for exactly one cycle per event. Back-to-back events give back-to-back pulses.
- Reset (reset=0), asynchronous, takes effect with no clock edge: idx=0, valid=0, illegal=0, seq_err=0, wrap=0, err_cnt=0, state=SYNC.
- Reset released mid-sequence: the first legal sample locks with no seq_err and no wrap.
- Reset asserted mid-operation: any pending pulse is cleared immediately.
- The upstream counter shares clk; no CDC is required.

## Structure
- Shared package johnson_pkg:
  - typedef enum {SYNC, TRACK} jd_state_t;
  - function jidx_width(N).
- Sub-module johnson_code_check, purely combinational: q → {legal, k}. Parameterized by N and reused by other Johnson consumers.
- johnson_decoder contains:
  - the FSM;
  - the idx, pulse and err_cnt registers;
  - the successor compare (mod 2N).

## Test plan
- Reset: hold reset=0 with clk running, then deassert → idx=0, valid=0, all pulses 0, err_cnt=0. Assert reset=0 between clock edges → outputs clear without an edge.
- Legal run (N=4): feed 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000 → after one cycle idx=0,1,…,7,0, valid=1 throughout, wrap pulses once on the final 0, err_cnt=0.
- Illegal code: in TRACK at idx=2, feed 0101 → illegal=1 for one cycle, valid=0, err_cnt=1. Then feed 0111 → valid=1, idx=3, seq_err=0.
- Skip and hold: idx=1, then feed 0111 → seq_err pulse, idx=3, err_cnt+1. Feed 0111 again → no error, idx=3.
- Saturation and clear (CW=2): inject 5 illegal codes → err_cnt=3. Raise err_clr on the same cycle as a 6th illegal code → err_cnt=0.
- Width sweep: N=8, 16, 32 with a full 2N-step legal run each → idx=0..2N−1, exactly one wrap per lap, no errors.

Source files
------------

// File: rtl/johnson_pkg.sv
// Shared types and helpers for consumers of the parameterized Johnson counter.
package johnson_pkg;

    typedef enum logic [0:0] {SYNC, TRACK} jd_state_t;

    // Width of a binary phase index for an N-bit Johnson code (2N states)
    function automatic int jidx_width(input int n);
        return $clog2(2 * n);
    endfunction

endpackage

// File: rtl/johnson_code_check.sv
// Combinational Johnson code checker: maps an N-bit code to its phase index
// and flags codes that are not one of the 2N legal patterns.
module johnson_code_check
    import johnson_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = jidx_width(N)
) (
    input  logic [N-1:0]  q,
    output logic          legal,
    output logic [IW-1:0] k
);

    logic [IW:0]  pop;
    logic [N-1:0] pattern;

    // MSB clear means ones fill from bit 0; MSB set means ones fill from the top
    always_comb begin
        pop = '0;
        for (int i = 0; i < N; i++) begin
            pop = pop + {{IW{1'b0}}, q[i]};
        end
        pattern = '0;
        for (int i = 0; i < N; i++) begin
            if (q[N-1]) begin
                pattern[i] = (i >= N - int'(pop));
            end else begin
                pattern[i] = (i < int'(pop));
            end
        end
        legal = (q == pattern);
        k     = q[N-1] ? IW'(2 * N - int'(pop)) : IW'(pop);
    end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson code decoder: binary phase index, legality and continuity checks,
// wrap strobe and a saturating error counter.
module johnson_decoder
    import johnson_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int CW = 8,
    localparam int IW = jidx_width(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  q,
    input  logic          err_clr,
    output logic [IW-1:0] idx,
    output logic          valid,
    output logic          illegal,
    output logic          seq_err,
    output logic          wrap,
    output logic [CW-1:0] err_cnt
);

    localparam logic [IW-1:0] LAST = IW'(2 * N - 1);

    jd_state_t     state, state_next;
    logic          legal;
    logic [IW-1:0] k;
    logic [IW-1:0] succ;
    logic [IW-1:0] idx_next;
    logic          illegal_next, seq_err_next, wrap_next;

    johnson_code_check #(.N(N)) u_check (
        .q     (q),
        .legal (legal),
        .k     (k)
    );

    // 2N need not be a power of two, so the successor wraps explicitly
    assign succ  = (idx == LAST) ? '0 : idx + 1'b1;
    assign valid = (state == TRACK);

    always_comb begin
        state_next   = state;
        idx_next     = idx;
        illegal_next = 1'b0;
        seq_err_next = 1'b0;
        wrap_next    = 1'b0;
        unique case (state)
            SYNC: begin
                if (legal) begin
                    idx_next   = k;
                    state_next = TRACK;
                end else begin
                    illegal_next = 1'b1;
                end
            end
            TRACK: begin
                if (!legal) begin
                    illegal_next = 1'b1;
                    state_next   = SYNC;
                end else if (k == succ) begin
                    idx_next  = k;
                    wrap_next = (idx == LAST);
                end else if (k != idx) begin
                    seq_err_next = 1'b1;
                    idx_next     = k;
                end
            end
            default: state_next = SYNC;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= SYNC;
            idx     <= '0;
            illegal <= 1'b0;
            seq_err <= 1'b0;
            wrap    <= 1'b0;
            err_cnt <= '0;
        end else begin
            state   <= state_next;
            idx     <= idx_next;
            illegal <= illegal_next;
            seq_err <= seq_err_next;
            wrap    <= wrap_next;
            if (err_clr) begin
                err_cnt <= '0;
            end else if ((illegal_next || seq_err_next) && (err_cnt != {CW{1'b1}})) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_johnson_decoder.sv
// Directed bench for johnson_decoder: N=4 main, N=4/CW=2 saturation, N=8/16/32 sweeps.
module tb_johnson_decoder;

    logic clk;
    logic reset;

    logic [3:0] q4;
    logic       clr4;
    logic [2:0] idx4;
    logic       valid4, ill4, seq4, wrap4;
    logic [7:0] cnt4;

    logic [3:0] qs;
    logic       clrs;
    logic [2:0] idxs;
    logic       valids, ills, seqs, wraps;
    logic [1:0] cnts;

    logic [7:0]  q8;
    logic [3:0]  idx8;
    logic        valid8, ill8, seq8, wrap8;
    logic [7:0]  cnt8;

    logic [15:0] q16;
    logic [4:0]  idx16;
    logic        valid16, ill16, seq16, wrap16;
    logic [7:0]  cnt16;

    logic [31:0] q32;
    logic [5:0]  idx32;
    logic        valid32, ill32, seq32, wrap32;
    logic [7:0]  cnt32;

    int tests_run;
    int tests_failed;

    johnson_decoder #(.N(4), .CW(8)) dut (
        .clk(clk), .reset(reset), .q(q4), .err_clr(clr4), .idx(idx4), .valid(valid4),
        .illegal(ill4), .seq_err(seq4), .wrap(wrap4), .err_cnt(cnt4)
    );

    johnson_decoder #(.N(4), .CW(2)) dut_sat (
        .clk(clk), .reset(reset), .q(qs), .err_clr(clrs), .idx(idxs), .valid(valids),
        .illegal(ills), .seq_err(seqs), .wrap(wraps), .err_cnt(cnts)
    );

    johnson_decoder #(.N(8), .CW(8)) dut8 (
        .clk(clk), .reset(reset), .q(q8), .err_clr(1'b0), .idx(idx8), .valid(valid8),
        .illegal(ill8), .seq_err(seq8), .wrap(wrap8), .err_cnt(cnt8)
    );

    johnson_decoder #(.N(16), .CW(8)) dut16 (
        .clk(clk), .reset(reset), .q(q16), .err_clr(1'b0), .idx(idx16), .valid(valid16),
        .illegal(ill16), .seq_err(seq16), .wrap(wrap16), .err_cnt(cnt16)
    );

    johnson_decoder #(.N(32), .CW(8)) dut32 (
        .clk(clk), .reset(reset), .q(q32), .err_clr(1'b0), .idx(idx32), .valid(valid32),
        .illegal(ill32), .seq_err(seq32), .wrap(wrap32), .err_cnt(cnt32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Johnson code for index k of an n-bit counter
    function automatic logic [63:0] jcode(input int n, input int k);
        logic [63:0] ones;
        ones = (64'd1 << n) - 64'd1;
        if (k <= n) return (64'd1 << k) - 64'd1;
        return (ones << (k - n)) & ones;
    endfunction

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too
    task automatic step4(input logic [3:0] code);
        q4 = code;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        q4 = 4'b0101; clr4 = 1'b0; qs = 4'b0000; clrs = 1'b0;
        q8 = '0; q16 = '0; q32 = '0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({idx4, valid4, ill4, seq4, wrap4} !== 7'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got %b expected 0000000", {idx4, valid4, ill4, seq4, wrap4});
        end
        tests_run++;
        if (cnt4 !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_err_cnt: got %0d expected 0", cnt4);
        end
        q4 = 4'b0000;
        reset = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (valid4 !== 1'b1 || idx4 !== 3'd0 || seq4 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL first_lock: got valid=%b idx=%0d seq=%b expected 1 0 0", valid4, idx4, seq4);
        end
    endtask

    task automatic test_legal_run();
        logic [3:0] codes [9] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
        logic [2:0] exp_idx [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
        for (int i = 0; i < 9; i++) begin
            step4(codes[i]);
            tests_run++;
            if (idx4 !== exp_idx[i] || valid4 !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL legal_idx[%0d]: got idx=%0d valid=%b expected idx=%0d valid=1", i, idx4, valid4, exp_idx[i]);
            end
            tests_run++;
            if (wrap4 !== (i == 8) || ill4 !== 1'b0 || seq4 !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL legal_pulses[%0d]: got wrap=%b ill=%b seq=%b expected wrap=%b 0 0", i, wrap4, ill4, seq4, (i == 8));
            end
        end
        tests_run++;
        if (cnt4 !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL legal_err_cnt: got %0d expected 0", cnt4);
        end
    endtask

    task automatic test_illegal();
        step4(4'b0001);
        step4(4'b0011);
        step4(4'b0101);
        tests_run++;
        if (ill4 !== 1'b1 || valid4 !== 1'b0 || idx4 !== 3'd2 || cnt4 !== 8'd1) begin
            tests_failed++;
            $display("[TB] FAIL illegal_detect: got ill=%b valid=%b idx=%0d cnt=%0d expected 1 0 2 1", ill4, valid4, idx4, cnt4);
        end
        step4(4'b0111);
        tests_run++;
        if (ill4 !== 1'b0 || valid4 !== 1'b1 || idx4 !== 3'd3 || seq4 !== 1'b0 || cnt4 !== 8'd1) begin
            tests_failed++;
            $display("[TB] FAIL illegal_relock: got ill=%b valid=%b idx=%0d seq=%b cnt=%0d expected 0 1 3 0 1", ill4, valid4, idx4, seq4, cnt4);
        end
    endtask

    task automatic test_back_to_back();
        step4(4'b1001);
        tests_run++;
        if (ill4 !== 1'b1 || cnt4 !== 8'd2) begin
            tests_failed++;
            $display("[TB] FAIL b2b_first: got ill=%b cnt=%0d expected 1 2", ill4, cnt4);
        end
        step4(4'b0100);
        tests_run++;
        if (ill4 !== 1'b1 || valid4 !== 1'b0 || cnt4 !== 8'd3) begin
            tests_failed++;
            $display("[TB] FAIL b2b_second: got ill=%b valid=%b cnt=%0d expected 1 0 3", ill4, valid4, cnt4);
        end
    endtask

    task automatic test_skip_hold();
        step4(4'b0001);
        tests_run++;
        if (idx4 !== 3'd1 || valid4 !== 1'b1 || seq4 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL skip_setup: got idx=%0d valid=%b seq=%b expected 1 1 0", idx4, valid4, seq4);
        end
        step4(4'b0111);
        tests_run++;
        if (seq4 !== 1'b1 || idx4 !== 3'd3 || cnt4 !== 8'd4 || ill4 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL skip_seq_err: got seq=%b idx=%0d cnt=%0d ill=%b expected 1 3 4 0", seq4, idx4, cnt4, ill4);
        end
        step4(4'b0111);
        tests_run++;
        if (seq4 !== 1'b0 || idx4 !== 3'd3 || cnt4 !== 8'd4 || valid4 !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL hold: got seq=%b idx=%0d cnt=%0d valid=%b expected 0 3 4 1", seq4, idx4, cnt4, valid4);
        end
        // Backward jump 3 -> 0 is also a continuity break, not a wrap
        step4(4'b0000);
        tests_run++;
        if (seq4 !== 1'b1 || wrap4 !== 1'b0 || idx4 !== 3'd0 || cnt4 !== 8'd5) begin
            tests_failed++;
            $display("[TB] FAIL backjump: got seq=%b wrap=%b idx=%0d cnt=%0d expected 1 0 0 5", seq4, wrap4, idx4, cnt4);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        for (int i = 0; i < 5; i++) begin
            qs = 4'b0101;
            @(posedge clk);
            #1;
            tests_run++;
            if (cnts !== exp_cnt[i] || ills !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL sat_cnt[%0d]: got cnt=%0d ill=%b expected %0d 1", i, cnts, ills, exp_cnt[i]);
            end
        end
        clrs = 1'b1;
        @(posedge clk);
        #1;
        clrs = 1'b0;
        tests_run++;
        if (cnts !== 2'd0 || ills !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL sat_clear: got cnt=%0d ill=%b expected 0 1", cnts, ills);
        end
        qs = 4'b0000;
    endtask

    task automatic test_async_reset();
        step4(4'b0110);
        tests_run++;
        if (ill4 !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL async_setup: got ill=%b expected 1", ill4);
        end
        #3;
        reset = 1'b0;
        #1;
        tests_run++;
        if ({idx4, valid4, ill4, seq4, wrap4} !== 7'b0 || cnt4 !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL async_clear: got %b cnt=%0d expected 0000000 cnt=0", {idx4, valid4, ill4, seq4, wrap4}, cnt4);
        end
        @(posedge clk);
        #1;
        q4 = 4'b0111;
        reset = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (idx4 !== 3'd3 || valid4 !== 1'b1 || seq4 !== 1'b0 || wrap4 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midseq_lock: got idx=%0d valid=%b seq=%b wrap=%b expected 3 1 0 0", idx4, valid4, seq4, wrap4);
        end
    endtask

    task automatic test_width_sweep();
        logic [63:0] code;
        logic [5:0]  expk;
        int w8, w16, w32, e8, e16, e32;
        w8 = 0; w16 = 0; w32 = 0; e8 = 0; e16 = 0; e32 = 0;
        for (int k = 1; k <= 16; k++) begin
            code = jcode(8, k % 16);
            q8 = code[7:0];
            expk = 6'(k % 16);
            @(posedge clk);
            #1;
            if (wrap8) w8++;
            if (ill8 || seq8 || !valid8) e8++;
            tests_run++;
            if (idx8 !== expk[3:0]) begin
                tests_failed++;
                $display("[TB] FAIL n8_idx[%0d]: got %0d expected %0d", k, idx8, expk[3:0]);
            end
        end
        for (int k = 1; k <= 32; k++) begin
            code = jcode(16, k % 32);
            q16 = code[15:0];
            expk = 6'(k % 32);
            @(posedge clk);
            #1;
            if (wrap16) w16++;
            if (ill16 || seq16 || !valid16) e16++;
            tests_run++;
            if (idx16 !== expk[4:0]) begin
                tests_failed++;
                $display("[TB] FAIL n16_idx[%0d]: got %0d expected %0d", k, idx16, expk[4:0]);
            end
        end
        for (int k = 1; k <= 64; k++) begin
            code = jcode(32, k % 64);
            q32 = code[31:0];
            expk = 6'(k % 64);
            @(posedge clk);
            #1;
            if (wrap32) w32++;
            if (ill32 || seq32 || !valid32) e32++;
            tests_run++;
            if (idx32 !== expk) begin
                tests_failed++;
                $display("[TB] FAIL n32_idx[%0d]: got %0d expected %0d", k, idx32, expk);
            end
        end
        tests_run++;
        if (w8 != 1 || w16 != 1 || w32 != 1) begin
            tests_failed++;
            $display("[TB] FAIL sweep_wraps: got %0d %0d %0d expected 1 1 1", w8, w16, w32);
        end
        tests_run++;
        if (e8 != 0 || e16 != 0 || e32 != 0 || cnt8 !== 8'd0 || cnt16 !== 8'd0 || cnt32 !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL sweep_errors: got %0d %0d %0d cnt %0d %0d %0d expected all 0", e8, e16, e32, cnt8, cnt16, cnt32);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_legal_run();
        test_illegal();
        test_back_to_back();
        test_skip_hold();
        test_saturation();
        test_async_reset();
        test_width_sweep();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
